// File: rtl/fifo_share_ctrl.sv
// Shares one FIFO between two round-robin write requesters and a single reader.
// Tracks occupancy, drives the FIFO enables/clear and returns read data with a valid strobe.
module fifo_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] fifo_data_in,
  output logic             fifo_en_write,
  output logic             fifo_en_read,
  output logic             fifo_rst,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic last_gnt;
  logic blocked;
  logic wr_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // fifo_rst is held high through reset, so it also forces grants/reads off then.
  assign blocked = fifo_rst | clr;
  assign wr_ok   = ~blocked & ~full;

  // On contention the requester that did not win last time gets the slot.
  assign gnt0 = wr_ok & req0 & (~req1 | last_gnt);
  assign gnt1 = wr_ok & req1 & (~req0 | ~last_gnt);

  assign fifo_en_write = gnt0 | gnt1;
  assign fifo_data_in  = gnt1 ? wdata1 : wdata0;
  assign fifo_en_read  = rd_req & ~empty & ~blocked;
  assign rd_data       = fifo_data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      last_gnt <= 1'b1;
      rd_valid <= 1'b0;
      fifo_rst <= 1'b1;
    end else begin
      fifo_rst <= clr;
      rd_valid <= fifo_en_read;
      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
      if (clr)
        count <= '0;
      else if (fifo_en_write && !fifo_en_read)
        count <= count + CNT_W'(1);
      else if (fifo_en_read && !fifo_en_write)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl: attached FIFO fixture plus a queue-based reference model.
module tb_fifo_share_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0, req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rd_valid, fifo_en_write, fifo_en_read, fifo_rst, full, empty;
  logic [WIDTH-1:0] rd_data, fifo_data_in, fifo_data_out;
  logic [CNT_W-1:0] count;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fifo_share_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_data_in(fifo_data_in), .fifo_en_write(fifo_en_write),
    .fifo_en_read(fifo_en_read), .fifo_rst(fifo_rst),
    .fifo_data_out(fifo_data_out), .full(full), .empty(empty), .count(count)
  );

  // Attached FIFO: registered read data, synchronous clear.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [3:0] wp, rp;
  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0; rp <= '0; fifo_data_out <= '0;
    end else begin
      if (fifo_en_write) begin mem[wp] <= fifo_data_in; wp <= wp + 4'd1; end
      if (fifo_en_read) begin fifo_data_out <= mem[rp]; rp <= rp + 4'd1; end
    end
  end

  // Reference model: contents as a queue, plus arbitration memory and pipeline flags.
  logic [WIDTH-1:0] q[$];
  int m_last = 1;
  bit m_rst = 1'b1;
  bit m_rdv = 1'b0;
  logic [WIDTH-1:0] m_rdata = '0;

  function automatic int exp_gnt();
    if (m_rst || clr || !reset || q.size() == DEPTH) return -1;
    if (req0 && req1) return (m_last == 1) ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  function automatic bit exp_rd();
    return rd_req && q.size() != 0 && !m_rst && !clr && reset;
  endfunction

  task automatic model_reset();
    q.delete(); m_last = 1; m_rst = 1'b1; m_rdv = 1'b0;
  endtask

  task automatic tick();
    int g; bit r;
    g = exp_gnt(); r = exp_rd();
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (r) m_rdata = q.pop_front();
      if (g >= 0) begin
        q.push_back(g == 1 ? wdata1 : wdata0);
        m_last = g;
      end
      m_rdv = r;
      if (clr) q.delete();
      m_rst = clr;
    end
    #1;
  endtask

  task automatic soft_clear();
    clr = 1'b1; tick(); clr = 1'b0; tick();
  endtask

  task automatic test_reset();
    logic [12:0] obs, expv;
    model_reset();
    #12;
    req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1;
    #1;
    obs  = {gnt0, gnt1, fifo_en_write, fifo_en_read, full, empty, fifo_rst, rd_valid, count};
    expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
    nchk++;
    if (obs !== expv) begin nerr++; $display("FAIL reset_state got=%b want=%b", obs, expv); end
    nchk++;
    if (rd_data !== 8'h00) begin nerr++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    nchk++;
    if ({fifo_rst, gnt0, gnt1, fifo_en_read} !== 4'b1000) begin
      nerr++; $display("FAIL release_cycle1 got=%b want=1000", {fifo_rst, gnt0, gnt1, fifo_en_read});
    end
    rd_req = 1'b0;
    tick();
    nchk++;
    if (fifo_rst !== 1'b0) begin nerr++; $display("FAIL release_fifo_rst got=%b want=0", fifo_rst); end
  endtask

  task automatic test_alternate();
    req0 = 1'b1; req1 = 1'b1; wdata0 = 8'hA0; wdata1 = 8'hB0; rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          fifo_data_in !== ((i % 2 == 0) ? 8'hA0 : 8'hB0)) begin
        nerr++; $display("FAIL alt_grant i=%0d got=%b/%h", i, {gnt0, gnt1}, fifo_data_in);
      end
      tick();
      nchk++;
      if (count !== CNT_W'(i + 1)) begin nerr++; $display("FAIL alt_count got=%0d want=%0d", count, i + 1); end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_fill();
    soft_clear();
    nchk++;
    if ({fifo_rst, count} !== 6'd0) begin nerr++; $display("FAIL fill_start got=%b want=0", {fifo_rst, count}); end
    for (int i = 0; i < DEPTH; i++) begin
      req0 = 1'b1; wdata0 = WIDTH'(i);
      #1;
      nchk++;
      if (gnt0 !== 1'b1) begin nerr++; $display("FAIL fill_gnt i=%0d got=%b want=1", i, gnt0); end
      tick();
    end
    nchk++;
    if ({full, count} !== {1'b1, 5'd16}) begin nerr++; $display("FAIL fill_full got=%b/%0d want=1/16", full, count); end
    req0 = 1'b1; wdata0 = 8'h55; rd_req = 1'b1;
    #1;
    nchk++;
    if ({gnt0, fifo_en_write, fifo_en_read} !== 3'b001) begin
      nerr++; $display("FAIL full_refuse got=%b want=001", {gnt0, fifo_en_write, fifo_en_read});
    end
    tick();
    req0 = 1'b0; rd_req = 1'b0;
    nchk++;
    if ({count, rd_valid, rd_data} !== {5'd15, 1'b1, 8'h00}) begin
      nerr++; $display("FAIL full_read got=%0d/%b/%h want=15/1/00", count, rd_valid, rd_data);
    end
  endtask

  task automatic test_read_burst();
    soft_clear();
    for (int i = 0; i < DEPTH; i++) begin req0 = 1'b1; wdata0 = WIDTH'(i); tick(); end
    req0 = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      nchk++;
      if (rd_valid !== 1'b1 || rd_data !== WIDTH'(i)) begin
        nerr++; $display("FAIL burst_read i=%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, WIDTH'(i));
      end
    end
    #1;
    nchk++;
    if ({empty, fifo_en_read} !== 2'b10) begin nerr++; $display("FAIL empty_read_en got=%b want=10", {empty, fifo_en_read}); end
    tick();
    nchk++;
    if (rd_valid !== 1'b0) begin nerr++; $display("FAIL empty_rd_valid got=%b want=0", rd_valid); end
    rd_req = 1'b0;
  endtask

  task automatic test_simul();
    soft_clear();
    for (int i = 0; i < 5; i++) begin req1 = 1'b1; wdata1 = WIDTH'($urandom); tick(); end
    req1 = 1'b0; req0 = 1'b1; wdata0 = WIDTH'($urandom); rd_req = 1'b1;
    #1;
    nchk++;
    if ({gnt0, fifo_en_read} !== 2'b11) begin nerr++; $display("FAIL simul_en got=%b want=11", {gnt0, fifo_en_read}); end
    tick();
    req0 = 1'b0; rd_req = 1'b0;
    nchk++;
    if ({count, rd_valid, rd_data} !== {5'd5, 1'b1, m_rdata}) begin
      nerr++; $display("FAIL simul_result got=%0d/%b/%h want=5/1/%h", count, rd_valid, rd_data, m_rdata);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 2; i++) begin req0 = 1'b1; wdata0 = WIDTH'($urandom); tick(); end
    nchk++;
    if (count !== 5'd7) begin nerr++; $display("FAIL clr_pre_count got=%0d want=7", count); end
    clr = 1'b1; req0 = 1'b1;
    #1;
    nchk++;
    if ({gnt0, gnt1, fifo_en_write} !== 3'b000) begin nerr++; $display("FAIL clr_nogrant got=%b want=000", {gnt0, gnt1, fifo_en_write}); end
    tick();
    clr = 1'b0;
    #1;
    nchk++;
    if ({count, fifo_rst, gnt0} !== {5'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL clr_after got=%0d/%b/%b want=0/1/0", count, fifo_rst, gnt0);
    end
    tick();
    nchk++;
    if (gnt0 !== 1'b1) begin nerr++; $display("FAIL clr_resume got=%b want=1", gnt0); end
    tick();
    req0 = 1'b0;
  endtask

  task automatic test_random();
    logic [12:0] obs, expv;
    int eg; bit er;
    for (int n = 0; n < 400; n++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); rd_req = ($urandom_range(0, 2) != 0);
      wdata0 = WIDTH'($urandom); wdata1 = WIDTH'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      #1;
      eg = exp_gnt(); er = exp_rd();
      obs  = {gnt0, gnt1, fifo_en_write, fifo_en_read, full, empty, fifo_rst, rd_valid, count};
      expv = {eg == 0, eg == 1, eg >= 0, er, q.size() == DEPTH, q.size() == 0, m_rst, m_rdv, CNT_W'(q.size())};
      nchk++;
      if (obs !== expv || fifo_data_in !== (eg == 1 ? wdata1 : wdata0)) begin
        nerr++; $display("FAIL rand_ctrl n=%0d got=%b/%h want=%b", n, obs, fifo_data_in, expv);
      end
      if (m_rdv) begin
        nchk++;
        if (rd_data !== m_rdata) begin nerr++; $display("FAIL rand_data n=%0d got=%h want=%h", n, rd_data, m_rdata); end
      end
      tick();
    end
    clr = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    soft_clear();
    for (int i = 0; i < 4; i++) begin req0 = 1'b1; wdata0 = WIDTH'($urandom); tick(); end
    rd_req = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    nchk++;
    if ({count, rd_valid, fifo_rst, gnt0, gnt1, fifo_en_write, fifo_en_read} !== {5'd0, 6'b010000}) begin
      nerr++; $display("FAIL reset_mid got=%b", {count, rd_valid, fifo_rst, gnt0, gnt1, fifo_en_write, fifo_en_read});
    end
    tick();
    reset = 1'b1;
    rd_req = 1'b0;
    tick();
    #1;
    nchk++;
    if ({gnt0, count} !== {1'b1, 5'd0}) begin nerr++; $display("FAIL reset_mid_resume got=%b want=1/0", {gnt0, count}); end
    tick();
    req0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_fill();
    test_read_burst();
    test_simul();
    test_clr();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fifo_share_ctrl.md
# fifo_share_ctrl

Controller that shares the 16-entry × 8-bit FIFO buffer between two write requesters and one reader. It arbitrates writes round-robin and tracks occupancy to generate full/empty/count. It issues the FIFO's write/read enables and synchronous clear, and returns read data with a valid strobe. It sits directly in front of the FIFO; the FIFO's clock is shared and its data ports are wired through this block.

## Interface
- `WIDTH`, 8, data width of requesters and FIFO
- `DEPTH`, 16, FIFO entries; must match the attached FIFO
- `CNT_W`, 5, occupancy counter width; holds 0..DEPTH

Ports:
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `clr` in 1: synchronous soft clear
- `req0`, `req1` in 1: write requests
- `wdata0`, `wdata1` in WIDTH: write data per requester
- `gnt0`, `gnt1` out 1: write accepted this cycle (combinational)
- `rd_req` in 1: read request
- `rd_valid` out 1: `rd_data` valid this cycle (registered)
- `rd_data` out WIDTH: passthrough of `fifo_data_out`
- `fifo_data_in` out WIDTH: muxed write data to FIFO
- `fifo_en_write`, `fifo_en_read` out 1: FIFO enables (combinational)
- `fifo_rst` out 1: FIFO synchronous clear, active-high (registered)
- `fifo_data_out` in WIDTH: FIFO read data
- `full`, `empty` out 1: occupancy flags (decoded from registered count)
- `count` out CNT_W: current occupancy (registered)

## Operation
- State: `count`, `last_gnt` (1 bit), `rd_valid` flop, `fifo_rst` flop.
- Reset values while `reset`=0:
  - `count`=0, `empty`=1, `full`=0
  - `last_gnt`=1, so requester 0 wins first
  - `rd_valid`=0, `fifo_rst`=1
  - `gnt0`, `gnt1`, `fifo_en_write`, `fifo_en_read` forced 0
  - `rd_data` follows `fifo_data_out`, which is 0 under FIFO reset
- `fifo_rst` deasserts on the first clock edge after `reset` releases, and on the edge after a cycle with `clr`=0.
- Blocked cycles: while `fifo_rst`=1 or `clr`=1, no grants and no read enables.
- `clr`=1 sets `count`=0 and `fifo_rst`=1 at the next edge. `last_gnt` is unchanged.
- Write arbitration, when `full`=0 and not blocked:
  - Only `req0` high: `gnt0`=1.
  - Only `req1` high: `gnt1`=1.
  - Both high: grant the requester not equal to `last_gnt`.
- `last_gnt` updates to the granted index on every grant.
- At most one grant per cycle. `fifo_en_write` = `gnt0` | `gnt1`. `fifo_data_in` = granted requester's data, else `wdata0`.
- Full: `full`=1 refuses all writes, even if a read occurs the same cycle. Requesters hold `req` until granted.
- Read: `fifo_en_read` = `rd_req` & ~`empty` & not blocked.
  - A read with `empty`=1 is ignored, even if a write occurs the same cycle.
  - `rd_valid` at the next edge equals `fifo_en_read`.
- Count update, per cycle:
  - write only: +1
  - read only: −1
  - both: unchanged
  - neither: unchanged
- Count range is 0..DEPTH; it never wraps. `full` = (`count`==DEPTH); `empty` = (`count`==0).
- Reset mid-operation: all state returns to reset values immediately and in-flight `rd_valid` is dropped.

## Timing
- Write accepted in cycle N (`req`&`gnt`): the FIFO captures data at the end of N, and `count` reflects it in N+1. The entry is first readable in N+1.
- Read issued in cycle N: `rd_valid`=1 and `rd_data` is valid in N+1. `rd_data` is meaningless when `rd_valid`=0.
- Back-to-back reads every cycle give back-to-back `rd_valid` with a 1-cycle latency.
- `full`/`empty` change only at clock edges, one cycle after the causing transfer.
- After `reset` release, the first possible grant is in cycle 2; cycle 1 still has `fifo_rst`=1.

## Test plan
- Reset, then hold `req0`=`req1`=1 with `wdata0`=0xA0, `wdata1`=0xB0 for 4 cycles.
  - Required: grants alternate 0,1,0,1 starting with `gnt0`.
  - `count` steps 1..4.
- Fill with 16 writes from `req0` (0x00..0x0F).
  - Required: `full`=1 and `count`=16.
  - A further `req0` with simultaneous `rd_req` gets no grant.
  - The read proceeds and `count` becomes 15.
- Read 16 entries back-to-back.
  - Required: `rd_valid` high 16 consecutive cycles with `rd_data` 0x00..0x0F in order.
  - `empty`=1 afterwards; an extra `rd_req` gives no `fifo_en_read` and no `rd_valid`.
- At `count`=5, issue a simultaneous grant and read.
  - Required: `count` stays 5; `rd_valid` next cycle.
- Assert `clr` at `count`=7.
  - Required: no grants that cycle, `count`=0 and `fifo_rst`=1 next cycle, grants resume the cycle after.
- Assert `reset` low mid-burst with a read in flight.
  - Required: immediate `count`=0, `rd_valid`=0, `fifo_rst`=1, and all enables 0.
